// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer: owns the PC, fetches over req/ack,
// presents one instruction per execute window, faults on a hung fetch.
module pc_sequencer #(
    parameter logic [29:0] RESET_ADDR = 30'h0000_0000,
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [29:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr,
    output logic        o_instr_valid,
    output logic [29:0] o_pc,
    output logic [29:0] o_incPc,
    input  logic        i_PCSrc,
    input  logic [29:0] i_target,
    input  logic        i_stall,
    output logic [31:0] o_retired,
    output logic        o_fault
);

    localparam int unsigned CW =
        (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [CW-1:0] LAST_WAIT =
        CW'((WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        EXEC,
        FAULT
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          timed_out;

    assign o_imem_addr = o_pc;
    assign o_incPc     = o_pc + 30'd1;

    // With WAIT_LIMIT == 0 the counter free-runs but never trips.
    assign timed_out = (WAIT_LIMIT != 0) && (wait_cnt == LAST_WAIT);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= BOOT;
            o_pc          <= RESET_ADDR;
            o_instr       <= 32'h0;
            o_retired     <= 32'h0;
            wait_cnt      <= '0;
            o_imem_req    <= 1'b0;
            o_instr_valid <= 1'b0;
            o_fault       <= 1'b0;
        end else begin
            unique case (state)
                BOOT: begin
                    state      <= FETCH;
                    wait_cnt   <= '0;
                    o_imem_req <= 1'b1;
                end
                FETCH: begin
                    if (i_imem_ack) begin
                        state         <= EXEC;
                        o_instr       <= i_imem_rdata;
                        o_imem_req    <= 1'b0;
                        o_instr_valid <= 1'b1;
                    end else if (timed_out) begin
                        state      <= FAULT;
                        o_imem_req <= 1'b0;
                        o_fault    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                EXEC: begin
                    if (!i_stall) begin
                        state         <= FETCH;
                        o_pc          <= i_PCSrc ? i_target : o_incPc;
                        o_retired     <= o_retired + 32'd1;
                        wait_cnt      <= '0;
                        o_imem_req    <= 1'b1;
                        o_instr_valid <= 1'b0;
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= FAULT;
                end
            endcase
        end
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch/execute sequencer that owns the program counter and drives the next-PC unit. It issues instruction-memory fetches with a req/ack handshake and presents each fetched instruction for one execute window. On retirement it commits either PC+1 or the redirect target supplied by the next-PC unit. It sits between the instruction memory and the core datapath and guards against a hung memory with a fetch timeout.

## Interface
- RESET_ADDR, 30'h0000_0000: word address loaded into PC on reset.
- WAIT_LIMIT, 16: max cycles a fetch may wait for ack before fault; 0 disables the timeout.

- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- o_imem_req  out  1  fetch request, held high until ack.
- o_imem_addr  out  30  word address of fetch; equals o_pc.
- i_imem_ack  in  1  fetch complete; i_imem_rdata valid this cycle.
- i_imem_rdata  in  32  instruction word.
- o_instr  out  32  latched instruction for the execute window.
- o_instr_valid  out  1  high during the execute window.
- o_pc  out  30  word address of current instruction.
- o_incPc  out  30  o_pc + 1, combinational, mod 2^30; feeds next-PC unit.
- i_PCSrc  in  1  redirect select from next-PC unit.
- i_target  in  30  redirect word address from next-PC unit.
- i_stall  in  1  datapath hold; extends the execute window.
- o_retired  out  32  count of retired instructions, mod 2^32.
- o_fault  out  1  sticky fetch-timeout flag.

## Operation
- States:
  - BOOT: one cycle after reset.
  - FETCH: request outstanding.
  - EXEC: instruction presented.
  - FAULT: terminal.
- BOOT -> FETCH unconditionally.
- FETCH:
  - o_imem_req=1, o_imem_addr=o_pc.
  - On i_imem_ack: o_instr <= i_imem_rdata, go to EXEC.
  - Otherwise the wait counter increments.
- Timeout (WAIT_LIMIT≠0):
  - Ack arriving with counter = WAIT_LIMIT-1 wins and goes to EXEC.
  - No ack with counter = WAIT_LIMIT-1 goes to FAULT.
  - The wait counter clears on every entry to FETCH.
- EXEC:
  - o_instr_valid=1.
  - i_PCSrc and i_target are sampled only here, on the cycle i_stall=0.
  - If i_stall=1, remain in EXEC; PC, o_instr and o_retired hold.
  - If i_stall=0:
    - o_pc <= i_PCSrc ? i_target : o_pc+1.
    - o_retired <= o_retired+1.
    - Go to FETCH.
- FAULT:
  - o_fault=1, o_imem_req=0, o_instr_valid=0.
  - PC and o_retired frozen.
  - Exits only on i_rst.
- i_imem_ack outside FETCH is ignored.
- PC arithmetic is 30-bit unsigned with wrap: 30'h3FFF_FFFF+1 = 0.
- o_retired wraps from 32'hFFFF_FFFF to 0.

## Timing
- Reset values:
  - state BOOT, o_pc=RESET_ADDR, o_instr=0, o_retired=0, wait counter 0.
  - o_imem_req=0, o_instr_valid=0, o_fault=0.
  - o_incPc=RESET_ADDR+1.
- i_rst is sampled every edge and wins over all other events, including mid-fetch, mid-stall and FAULT.
- Cycle 0 = first edge with i_rst=0: BOOT. FETCH with req=1 is visible in cycle 1.
- Ack in cycle N (ack may be high in the first FETCH cycle): o_instr_valid=1 in cycle N+1.
- Unstalled instruction with single-cycle ack: 2 cycles per instruction (FETCH, EXEC).
- New o_pc is visible in the first cycle of the following FETCH.
- o_imem_req never drops in FETCH before ack, and never rises in EXEC.
- All outputs are registered except o_incPc and o_imem_addr, which follow o_pc.

## Test plan
- Sequential run:
  - Stimulus: RESET_ADDR=0, ack each FETCH cycle, PCSrc=0.
  - Required: fetch addresses 0,1,2,3; o_instr_valid every other cycle; o_retired=4 after 8 cycles.
- Redirect:
  - Stimulus: at EXEC of pc=5, i_PCSrc=1, i_target=30'h100.
  - Required: next o_imem_addr=30'h100; o_retired increments once.
- Stall:
  - Stimulus: i_stall=1 for 3 cycles in EXEC of pc=7, with i_PCSrc toggling during the stall; then i_stall=0 with i_PCSrc=0.
  - Required: o_instr_valid held 4 cycles; o_pc stays 7, then becomes 8; o_retired +1 only.
- Slow memory / timeout boundary, WAIT_LIMIT=4:
  - Ack on the 4th FETCH cycle -> EXEC.
  - No ack for 4 cycles -> o_fault=1, req=0; later ack ignored.
  - i_rst -> all outputs back to reset values.
- Wrap:
  - Stimulus: RESET_ADDR=30'h3FFF_FFFF, ack immediately.
  - Required: o_incPc=0 in EXEC; second fetch address 0.
- Reset mid-fetch:
  - Stimulus: i_rst=1 while req outstanding, with ack in the same cycle.
  - Required: next cycle is BOOT; o_pc=RESET_ADDR; o_instr=0; o_instr_valid=0.
